// File: rtl/aes_v3_pkg.sv
// aes_v3_pkg: GF(2^8) arithmetic, (Inv)MixColumn coefficients, operand bundle and FSM
// encoding shared by the sequential saes.v3 unit.
package aes_v3_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} aes_v3_state_e;

    typedef struct packed {
        logic        dec;
        logic        mix;
        logic        word;
        logic [1:0]  bs;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } aes_v3_op_t;

    // Coefficients per column byte, most significant byte first.
    localparam logic [15:0] MixEncCoef = {4'd3, 4'd1, 4'd1, 4'd2};
    localparam logic [15:0] MixDecCoef = {4'd11, 4'd13, 4'd9, 4'd14};

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    localparam logic [7:0] InvExp = 8'hFE;

    function automatic bit sboxes_legal(input int unsigned n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

    function automatic logic [7:0] xt2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt2(p);
        end
        return r;
    endfunction

    function automatic logic [7:0] xtn(input logic [7:0] a, input logic [3:0] n);
        return gf_mul(a, {4'h0, n});
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (InvExp[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_v3_seq_if.sv
// aes_v3_seq_if: valid/ready request and result bundle between the crypto FU and aes_v3_seq.
interface aes_v3_seq_if;
    logic        valid;
    logic        dec;
    logic        mix;
    logic        word;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  bs;
    logic [31:0] rd;
    logic        ready;

    modport master (output valid, dec, mix, word, rs1, rs2, bs, input rd, ready);
    modport slave  (input valid, dec, mix, word, rs1, rs2, bs, output rd, ready);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: forward / inverse AES S-box computed as GF(2^8) inversion plus affine map.
module aes_sbox
    import aes_v3_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);
    logic [7:0] inv_aff;
    logic [7:0] pre;
    logic [7:0] fwd_aff;

    always_comb begin
        inv_aff = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
        pre     = gf_inv(inv ? inv_aff : din);
        fwd_aff = pre ^ {pre[6:0], pre[7]} ^ {pre[5:0], pre[7:6]} ^ {pre[4:0], pre[7:5]}
                ^ {pre[3:0], pre[7:4]} ^ 8'h63;
        dout    = inv ? pre : fwd_aff;
    end
endmodule

// File: rtl/aes_v3_lane.sv
// aes_v3_lane: one S-box lane -- substitute, optional (Inv)MixColumn column, rotate into place.
module aes_v3_lane
    import aes_v3_pkg::*;
(
    input  logic        en,
    input  logic        dec,
    input  logic        mix,
    input  logic [7:0]  b,
    input  logic [1:0]  idx,
    output logic [31:0] m
);
    logic [7:0]  s;
    logic [15:0] coef;
    logic [31:0] col;

    aes_sbox u_sbox (
        .din  (b),
        .inv  (dec),
        .dout (s)
    );

    always_comb begin
        coef = dec ? MixDecCoef : MixEncCoef;
        col  = {24'h0, s};
        if (mix) begin
            col = {xtn(s, coef[15:12]), xtn(s, coef[11:8]), xtn(s, coef[7:4]), xtn(s, coef[3:0])};
        end
        m = '0;
        if (en) begin
            case (idx)
                2'd0: m = col;
                2'd1: m = {col[23:0], col[31:24]};
                2'd2: m = {col[15:0], col[31:16]};
                2'd3: m = {col[7:0], col[31:8]};
                default: m = '0;
            endcase
        end
    end
endmodule

// File: rtl/aes_v3_seq.sv
// aes_v3_seq: sequential saes.v3 encs/encm/decs/decm, byte or full-word, over SBOXES shared lanes.
// Optional AES_V3_SEQ_RDCLR_EN: rd reads zero outside the ready cycle, operands wiped in IDLE.
module aes_v3_seq
    import aes_v3_pkg::*;
#(
    parameter int unsigned SBOXES = 1
) (
    input logic         g_clk,
    input logic         g_resetn,
    aes_v3_seq_if.slave bus
);
    // Illegal lane counts fall back to a single lane rather than building a broken schedule.
    localparam int unsigned Lanes   = sboxes_legal(SBOXES) ? SBOXES : 32'd1;
    localparam logic [1:0]  LastCnt = 2'(4 / Lanes - 1);

    aes_v3_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   rd_q, rd_d;
    logic          ready_q, ready_d;
    aes_v3_op_t    op_q, op_d, op_idle;

    logic [Lanes-1:0] lane_en;
    logic [7:0]       lane_b   [Lanes];
    logic [1:0]       lane_idx [Lanes];
    logic [31:0]      lane_m   [Lanes];
    logic [31:0]      lane_xor;

`ifdef AES_V3_SEQ_RDCLR_EN
    assign op_idle = '0;
    assign bus.rd  = ready_q ? rd_q : '0;
`else
    assign op_idle = op_q;
    assign bus.rd  = rd_q;
`endif
    assign bus.ready = ready_q;

    // Byte mode drives only lane 0 with byte bs; word mode walks cnt*Lanes+k.
    always_comb begin
        for (int k = 0; k < Lanes; k++) begin
            lane_idx[k] = op_q.word ? 2'(cnt_q * 2'(Lanes) + 2'(k)) : op_q.bs;
            lane_b[k]   = op_q.rs1[8*lane_idx[k] +: 8];
            lane_en[k]  = op_q.word || (k == 0);
        end
    end

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        aes_v3_lane u_lane (
            .en  (lane_en[k]),
            .dec (op_q.dec),
            .mix (op_q.mix),
            .b   (lane_b[k]),
            .idx (lane_idx[k]),
            .m   (lane_m[k])
        );
    end

    always_comb begin
        lane_xor = '0;
        for (int k = 0; k < Lanes; k++) begin
            lane_xor = lane_xor ^ lane_m[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.valid) begin
                    op_d    = '{dec: bus.dec, mix: bus.mix, word: bus.word, bs: bus.bs,
                                rs1: bus.rs1, rs2: bus.rs2};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!bus.valid) begin
                    state_d = StIdle;
                    op_d    = op_idle;
                end else begin
                    acc_d = acc_q ^ lane_xor;
                    if (!op_q.word || cnt_q == LastCnt) begin
                        rd_d    = acc_d ^ op_q.rs2;
                        ready_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                op_d    = op_idle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_aes_v3_seq.sv
// tb_aes_v3_seq: directed + random checks of aes_v3_seq at SBOXES = 1, 2 and 4 against a
// table-driven model of the saes.v3 byte/word functions.
module tb_aes_v3_seq;
    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    logic [2:0]  valid_v;
    logic        dec, mix, word;
    logic [31:0] rs1, rs2;
    logic [1:0]  bs;
    logic [31:0] rd_w [3];
    logic [2:0]  ready_w;

    aes_v3_seq_if if0 ();
    aes_v3_seq_if if1 ();
    aes_v3_seq_if if2 ();

    assign if0.valid = valid_v[0];
    assign if1.valid = valid_v[1];
    assign if2.valid = valid_v[2];
    assign {if0.dec, if0.mix, if0.word, if0.rs1, if0.rs2, if0.bs} = {dec, mix, word, rs1, rs2, bs};
    assign {if1.dec, if1.mix, if1.word, if1.rs1, if1.rs2, if1.bs} = {dec, mix, word, rs1, rs2, bs};
    assign {if2.dec, if2.mix, if2.word, if2.rs1, if2.rs2, if2.bs} = {dec, mix, word, rs1, rs2, bs};
    assign rd_w[0] = if0.rd;
    assign rd_w[1] = if1.rd;
    assign rd_w[2] = if2.rd;
    assign ready_w = {if2.ready, if1.ready, if0.ready};

    aes_v3_seq #(.SBOXES(1)) u_dut0 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if0));
    aes_v3_seq #(.SBOXES(2)) u_dut1 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if1));
    aes_v3_seq #(.SBOXES(4)) u_dut2 (.g_clk(g_clk), .g_resetn(g_resetn), .bus(if2));

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]  sbox_t  [256];
    logic [7:0]  isbox_t [256];
    logic [31:0] exp_rd [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] held   [3] = '{32'h0, 32'h0, 32'h0};
    logic [2:0]  pending = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Carry-less product, then polynomial reduction mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [31:0] f_byte(input logic [7:0] b, input int i, input logic d,
                                           input logic m);
        logic [7:0]  s;
        logic [31:0] col;
        logic [63:0] dbl;
        s = d ? isbox_t[b] : sbox_t[b];
        if (!m)     col = {24'h0, s};
        else if (d) col = {gmul(s, 8'd11), gmul(s, 8'd13), gmul(s, 8'd9), gmul(s, 8'd14)};
        else        col = {gmul(s, 8'd3), s, s, gmul(s, 8'd2)};
        dbl = {col, col};
        return dbl[63-8*i -: 32];
    endfunction

    function automatic logic [31:0] model(input logic d, input logic m, input logic w,
                                          input logic [31:0] a, input logic [31:0] k,
                                          input logic [1:0] b);
        logic [31:0] acc;
        acc = 32'h0;
        if (w) for (int i = 0; i < 4; i++) acc = acc ^ f_byte(a[8*i +: 8], i, d, m);
        else   acc = f_byte(a[8*b +: 8], int'(b), d, m);
        return acc ^ k;
    endfunction

    function automatic int word_lat(input int j);
        return 1 + 4 / (1 << j);
    endfunction

    // Every cycle: result on ready, otherwise held (or cleared) value; no unexpected ready.
    always @(negedge g_clk) begin
        for (int j = 0; j < 3; j++) begin
            if (ready_w[j]) begin
                check("ready_expected", {31'b0, pending[j]}, 32'd1);
                check("rd_result", rd_w[j], exp_rd[j]);
                held[j]    = exp_rd[j];
                pending[j] = 1'b0;
            end else begin
`ifdef AES_V3_SEQ_RDCLR_EN
                check("rd_cleared", rd_w[j], 32'h0);
`else
                check("rd_held", rd_w[j], held[j]);
`endif
            end
        end
    end

    task automatic xact(input int j, input logic d, input logic m, input logic w,
                        input logic [31:0] a, input logic [31:0] k, input logic [1:0] b,
                        input logic [31:0] lit, input bit use_lit);
        logic [31:0] e;
        int cyc;
        bit got;
        @(negedge g_clk);
        {dec, mix, word, rs1, rs2, bs} = {d, m, w, a, k, b};
        e = model(d, m, w, a, k, b);
        if (use_lit) check("model_pin", e, lit);
        exp_rd[j]  = use_lit ? lit : e;
        pending[j] = 1'b1;
        valid_v[j] = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(posedge g_clk);
            #1;
            cyc++;
            if (ready_w[j]) got = 1'b1;
            else {dec, mix, word, rs1, rs2, bs} = {$urandom, $urandom, $urandom};
        end
        check("latency", cyc, w ? word_lat(j) : 2);
        @(negedge g_clk);
        valid_v[j] = 1'b0;
        @(posedge g_clk);
        #1;
        check("ready_one_cycle", {31'b0, ready_w[j]}, 32'd0);
    endtask

    initial begin
        logic [7:0] p, q;
        int cyc, n_rdy;
        for (int i = 0; i < 256; i++) sbox_t[i] = 8'h00;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
        check("pin_sbox_53", {24'h0, sbox_t[8'h53]}, 32'hED);
        check("pin_sbox_01", {24'h0, sbox_t[8'h01]}, 32'h7C);
        check("pin_isbox_7c", {24'h0, isbox_t[8'h7C]}, 32'h01);
        check("pin_gmul_ed3", {24'h0, gmul(8'hED, 8'h03)}, 32'h2C);
        check("pin_gmul_5713", {24'h0, gmul(8'h57, 8'h13)}, 32'hFE);

        g_resetn = 1'b0;
        valid_v  = 3'b000;
        {dec, mix, word, rs1, rs2, bs} = '0;
        #12;
        for (int j = 0; j < 3; j++) begin
            check("reset_ready", {31'b0, ready_w[j]}, 32'd0);
            check("reset_rd", rd_w[j], 32'h0);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;

        xact(0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'd0, 32'h0000_0063, 1'b1);
        xact(0, 1'b0, 1'b1, 1'b0, 32'h0000_5300, 32'h0000_0000, 2'd1, 32'hEDED_C12C, 1'b1);
        xact(0, 1'b1, 1'b0, 1'b0, 32'h7C00_0000, 32'hFFFF_FFFF, 2'd3, 32'hFEFF_FFFF, 1'b1);
        for (int j = 0; j < 3; j++) begin
            xact(j, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 2'd0, 32'h6363_6363, 1'b1);
            xact(j, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 2'd2, 32'h6363_6363, 1'b1);
            xact(j, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 2'd1, 32'h5252_5252, 1'b1);
        end

        // Abort: drop valid after two BUSY cycles of a word op on the 1-lane unit.
        @(negedge g_clk);
        {dec, mix, word, rs1, rs2, bs} = {1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 2'd0};
        exp_rd[0]  = 32'hDEAD_BEEF;
        pending[0] = 1'b1;
        valid_v[0] = 1'b1;
        @(posedge g_clk);
        @(posedge g_clk);
        @(negedge g_clk);
        valid_v[0] = 1'b0;
        pending[0] = 1'b0;
        n_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge g_clk);
            #1;
            if (ready_w[0]) n_rdy++;
        end
        check("abort_no_ready", n_rdy, 0);
        xact(0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 2'd0, 32'h6363_6363, 1'b1);

        // Asynchronous reset in the middle of a word op.
        @(negedge g_clk);
        {dec, mix, word, rs1, rs2, bs} = {1'b1, 1'b1, 1'b1, 32'hA5A5_0F0F, 32'h1111_2222, 2'd0};
        exp_rd[0]  = 32'hDEAD_BEEF;
        pending[0] = 1'b1;
        valid_v[0] = 1'b1;
        @(posedge g_clk);
        @(posedge g_clk);
        #2;
        g_resetn   = 1'b0;
        valid_v[0] = 1'b0;
        pending    = 3'b000;
        for (int j = 0; j < 3; j++) held[j] = 32'h0;
        #1;
        check("reset_mid_ready", {31'b0, ready_w[0]}, 32'd0);
        check("reset_mid_rd", rd_w[0], 32'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;

        // valid left high through DONE: re-accepted from IDLE, not in DONE.
        @(negedge g_clk);
        {dec, mix, word, rs1, rs2, bs} = {1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0, 2'd0};
        exp_rd[0]  = 32'h0000_007C;
        pending[0] = 1'b1;
        valid_v[0] = 1'b1;
        cyc = 0;
        while (cyc < 20 && !ready_w[0]) begin
            @(posedge g_clk);
            #1;
            cyc++;
        end
        check("b2b_first_latency", cyc, 2);
        @(negedge g_clk);
        #1;
        pending[0] = 1'b1;
        cyc = 0;
        do begin
            @(posedge g_clk);
            #1;
            cyc++;
        end while (cyc < 20 && !ready_w[0]);
        check("b2b_gap", cyc, 3);
        @(negedge g_clk);
        valid_v[0] = 1'b0;
        @(posedge g_clk);
        #1;
        check("b2b_ready_one_cycle", {31'b0, ready_w[0]}, 32'd0);

        for (int n = 0; n < 36; n++) begin
            xact(n % 3, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                 2'($urandom_range(3)), 32'h0, 1'b0);
        end

        repeat (2) @(posedge g_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
